apb_req_bridge: RTL and testbench
=================================

Name: apb_req_bridge

Overview:
Parametrised APB4 requester that turns a valid/ready command stream into APB transfers across NUM_SLV decoded slave regions. It returns each completion on a valid/ready response channel. It generalises our fixed 32-bit, single-PSEL APB usage with configurable address/data width, multi-slave PSEL decode, an access-phase timeout and out-of-range error generation. It sits between a local command source (CPU shim, DMA, test sequencer) and the peripheral APB fabric (GPIO and siblings).

Parameters:
ADDR_W, 32, paddr/cmd_addr width
DATA_W, 32, data width; must be 8, 16 or 32; strobe width STRB_W = DATA_W/8
NUM_SLV, 4, number of PSEL outputs, 1..16
SLV_SPAN_LOG2, 12, log2 of bytes per slave region; slave index = addr[SLV_SPAN_LOG2 +: IDX_W], IDX_W = max(1, clog2(NUM_SLV))
TIMEOUT, 256, max ACCESS-phase cycles before abort; 0 disables the timeout

Ports:
pclk  in  1  clock
preset  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  STRB_W  write byte strobes
cmd_prot  in  3  APB4 protection
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  pslverr, timeout or decode error
rsp_timeout  out  1  error was a timeout
paddr  out  ADDR_W  APB address
psel  out  NUM_SLV  one-hot slave select
penable  out  1  access phase
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
pstrb  out  STRB_W  APB strobes; forced 0 on reads
pprot  out  3  APB protection
pready  in  NUM_SLV  per-slave ready
prdata  in  NUM_SLV*DATA_W  per-slave read data, slave i at [i*DATA_W +: DATA_W]
pslverr  in  NUM_SLV  per-slave error

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, including cmd_ready. State = IDLE. cmd_ready rises the first cycle after preset deasserts.
- States: IDLE, SETUP, ACCESS, RESP.
  - IDLE: cmd_ready = 1. On accept, latch the command and compute the index.
    - index >= NUM_SLV: go to RESP with rsp_err = 1, rsp_timeout = 0, rdata = 0. No bus activity.
    - Otherwise go to SETUP.
  - SETUP: psel[idx] = 1, penable = 0, paddr/pwrite/pwdata/pstrb/pprot driven. Always go to ACCESS next cycle.
  - ACCESS: psel[idx] = 1, penable = 1. Wait counter starts at 0 and increments each cycle.
    - pready[idx] = 1: capture prdata slice (reads only), capture pslverr[idx]; go to RESP.
    - TIMEOUT != 0, counter == TIMEOUT-1 and no pready: go to RESP with rsp_err = 1, rsp_timeout = 1.
  - RESP: psel = 0, penable = 0, rsp_valid = 1, cmd_ready = 0. Fields are held stable until rsp_ready; then go to IDLE.
- APB control stability: paddr, pwrite, pwdata, pstrb and pprot are constant from SETUP through the last ACCESS cycle. They hold their last values while idle.
- Only the selected slave's pready/prdata/pslverr are observed. Others are ignored, even if asserted.
- Latency with a zero-wait slave and rsp_ready held high:
  - accept at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3, next accept at cycle 4.
  - Throughput is one transfer per 4 cycles.
- Each APB wait state adds 1 cycle.
- Commands are never lost: cmd_ready is low outside IDLE.
- Timeout abort: psel/penable drop the cycle after the abort, even without pready. A late pready from that slave is ignored.
- preset asserted in any state: next edge goes to IDLE with all outputs 0. Any in-flight transfer is dropped and no response is produced.

Decomposition:
- Package apb_req_bridge_pkg:
  - state enum bridge_state_e (IDLE/SETUP/ACCESS/RESP)
  - typedef apb_prot_t (logic [2:0])
  - localparam function for IDX_W
  - response struct (rdata, err, timeout) parametrised via DATA_W-independent max width 32
- One sub-module, apb_req_timeout_cnt:
  - clear/enable/expire, parameter TIMEOUT
  - TIMEOUT = 0 ties expire to 0

Test Plan:
- Zero-wait write: cmd 0x0000_0010, data 0xDEAD_BEEF, strb 0xF to slave 0 -> psel = 0001 at cycle 1, penable at cycle 2, rsp_valid at cycle 3, err = 0, rdata = 0.
- Read with 3 wait states from slave 2 (addr 0x2004, prdata 0x1234_5678) -> paddr/pstrb = 0 stable for 4 ACCESS cycles, rsp_rdata = 0x1234_5678 at cycle 6.
- pslverr: read slave 1 returning pready = 1, pslverr = 1 -> rsp_err = 1, rsp_timeout = 0. Simultaneous pready on slave 3 is ignored.
- Timeout, TIMEOUT = 16, slave never ready -> exactly 16 ACCESS cycles, psel = 0 next cycle, rsp_err = 1, rsp_timeout = 1. A later pready causes no effect.
- Decode error, NUM_SLV = 3, addr 0x3000 -> no psel ever, rsp_err = 1 one cycle after accept.
- rsp_ready low for 5 cycles, then preset mid-ACCESS on the next transfer:
  - response held stable and cmd_ready = 0 throughout
  - after reset: all outputs 0, no response, cmd_ready = 1 on the cycle after release.

Source files
------------

// File: rtl/apb_req_bridge_pkg.sv
// Shared types and helpers for the APB4 requester bridge.
package apb_req_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } bridge_state_e;

    typedef logic [2:0] apb_prot_t;

    // Response storage is sized for the widest legal data bus.
    localparam int RSP_MAX_W = 32;

    typedef struct packed {
        logic [RSP_MAX_W-1:0] rdata;
        logic                 err;
        logic                 timeout;
    } bridge_rsp_t;

    function automatic int idx_width(input int num_slv);
        return (num_slv <= 1) ? 1 : $clog2(num_slv);
    endfunction

endpackage

// File: rtl/apb_req_bridge_if.sv
// Command/response stream plus the APB requester bus of apb_req_bridge.
// master = bridge side; slave = command source and APB fabric side.
interface apb_req_bridge_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4
);
    import apb_req_bridge_pkg::*;

    localparam int STRB_W = DATA_W / 8;

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [ADDR_W-1:0]         cmd_addr;
    logic [DATA_W-1:0]         cmd_wdata;
    logic [STRB_W-1:0]         cmd_strb;
    apb_prot_t                 cmd_prot;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      rsp_timeout;

    logic [ADDR_W-1:0]         paddr;
    logic [NUM_SLV-1:0]        psel;
    logic                      penable;
    logic                      pwrite;
    logic [DATA_W-1:0]         pwdata;
    logic [STRB_W-1:0]         pstrb;
    apb_prot_t                 pprot;
    logic [NUM_SLV-1:0]        pready;
    logic [NUM_SLV*DATA_W-1:0] prdata;
    logic [NUM_SLV-1:0]        pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  rsp_ready,
        input  pready, prdata, pslverr,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output rsp_ready,
        output pready, prdata, pslverr,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot
    );

endinterface

// File: rtl/apb_req_timeout_cnt.sv
// ACCESS-phase wait counter; expire is high on the last permitted wait cycle.
// TIMEOUT = 0 disables the abort entirely.
module apb_req_timeout_cnt #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    if (TIMEOUT == 0) begin : g_off
        logic unused_inputs;
        assign unused_inputs = ^{clk, rst, clear, enable};
        assign expire        = 1'b0;
    end else begin : g_on
        localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

        logic [CNT_W-1:0] count_q;

        always_ff @(posedge clk) begin
            if (rst || clear) begin
                count_q <= '0;
            end else if (enable && !expire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end

        assign expire = enable && (count_q == CNT_W'(TIMEOUT - 1));
    end

endmodule

// File: rtl/apb_req_bridge.sv
// APB4 requester: one valid/ready command in, one APB transfer out, one response back.
// Every output is a flop; the comb process computes next values for all of them.
module apb_req_bridge
    import apb_req_bridge_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int NUM_SLV       = 4,
    parameter int SLV_SPAN_LOG2 = 12,
    parameter int TIMEOUT       = 256
) (
    input  logic             pclk,
    input  logic             preset,
    apb_req_bridge_if.master bus
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = idx_width(NUM_SLV);

    bridge_state_e      state_q, state_n;
    logic               cmd_ready_q, cmd_ready_n;
    logic [NUM_SLV-1:0] psel_q, psel_n;
    logic               penable_q, penable_n;
    logic [ADDR_W-1:0]  paddr_q, paddr_n;
    logic               pwrite_q, pwrite_n;
    logic [DATA_W-1:0]  pwdata_q, pwdata_n;
    logic [STRB_W-1:0]  pstrb_q, pstrb_n;
    apb_prot_t          pprot_q, pprot_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic               rsp_valid_q, rsp_valid_n;
    bridge_rsp_t        rsp_q, rsp_n;

    logic [IDX_W-1:0]   cmd_idx;
    logic               sel_ready;
    logic               sel_err;
    logic [DATA_W-1:0]  sel_rdata;
    logic               tmo_clear;
    logic               tmo_enable;
    logic               tmo_expire;

    // Only the latched slave's response lines are ever looked at.
    assign cmd_idx   = bus.cmd_addr[SLV_SPAN_LOG2 +: IDX_W];
    assign sel_ready = bus.pready[idx_q];
    assign sel_err   = bus.pslverr[idx_q];
    assign sel_rdata = bus.prdata[32'(idx_q) * DATA_W +: DATA_W];

    assign tmo_clear  = (state_q != ACCESS);
    assign tmo_enable = (state_q == ACCESS);

    apb_req_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (pclk),
        .rst    (preset),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expire (tmo_expire)
    );

    always_comb begin
        state_n     = state_q;
        cmd_ready_n = 1'b0;
        psel_n      = psel_q;
        penable_n   = penable_q;
        paddr_n     = paddr_q;
        pwrite_n    = pwrite_q;
        pwdata_n    = pwdata_q;
        pstrb_n     = pstrb_q;
        pprot_n     = pprot_q;
        idx_n       = idx_q;
        rsp_valid_n = rsp_valid_q;
        rsp_n       = rsp_q;

        unique case (state_q)
            IDLE: begin
                cmd_ready_n = 1'b1;
                if (cmd_ready_q && bus.cmd_valid) begin
                    cmd_ready_n = 1'b0;
                    if (32'(cmd_idx) >= 32'(NUM_SLV)) begin
                        // Decode miss: answer immediately without touching the bus.
                        state_n       = RESP;
                        rsp_valid_n   = 1'b1;
                        rsp_n.rdata   = '0;
                        rsp_n.err     = 1'b1;
                        rsp_n.timeout = 1'b0;
                    end else begin
                        state_n         = SETUP;
                        idx_n           = cmd_idx;
                        psel_n          = '0;
                        psel_n[cmd_idx] = 1'b1;
                        penable_n       = 1'b0;
                        paddr_n         = bus.cmd_addr;
                        pwrite_n        = bus.cmd_write;
                        pwdata_n        = bus.cmd_wdata;
                        pstrb_n         = bus.cmd_write ? bus.cmd_strb : '0;
                        pprot_n         = bus.cmd_prot;
                    end
                end
            end

            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
            end

            ACCESS: begin
                if (sel_ready) begin
                    state_n       = RESP;
                    psel_n        = '0;
                    penable_n     = 1'b0;
                    rsp_valid_n   = 1'b1;
                    rsp_n.rdata   = (pwrite_q || sel_err) ? '0 : RSP_MAX_W'(sel_rdata);
                    rsp_n.err     = sel_err;
                    rsp_n.timeout = 1'b0;
                end else if (tmo_expire) begin
                    state_n       = RESP;
                    psel_n        = '0;
                    penable_n     = 1'b0;
                    rsp_valid_n   = 1'b1;
                    rsp_n.rdata   = '0;
                    rsp_n.err     = 1'b1;
                    rsp_n.timeout = 1'b1;
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_n     = IDLE;
                    cmd_ready_n = 1'b1;
                    rsp_valid_n = 1'b0;
                    rsp_n       = '0;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            idx_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_n;
            cmd_ready_q <= cmd_ready_n;
            psel_q      <= psel_n;
            penable_q   <= penable_n;
            paddr_q     <= paddr_n;
            pwrite_q    <= pwrite_n;
            pwdata_q    <= pwdata_n;
            pstrb_q     <= pstrb_n;
            pprot_q     <= pprot_n;
            idx_q       <= idx_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_q       <= rsp_n;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pstrb       = pstrb_q;
    assign bus.pprot       = pprot_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_q.rdata[DATA_W-1:0];
    assign bus.rsp_err     = rsp_q.err;
    assign bus.rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Bench for apb_req_bridge: a 4-slave/TIMEOUT=16 instance for transfers and a
// 3-slave/TIMEOUT=0 instance for decode errors and unbounded waits.
module tb_apb_req_bridge;

    localparam int NS  = 4;
    localparam int TMO = 16;

    logic pclk = 1'b0;
    logic preset;
    int   assertCount = 0;
    int   failCount   = 0;

    apb_req_bridge_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(NS)) bus_a ();
    apb_req_bridge_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3))  bus_b ();

    apb_req_bridge #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(NS), .SLV_SPAN_LOG2(12), .TIMEOUT(TMO)
    ) u_dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus_a)
    );

    apb_req_bridge #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .SLV_SPAN_LOG2(12), .TIMEOUT(0)
    ) u_dec (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus_b)
    );

    always #5 pclk = ~pclk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_cmd_ready"},   bus_a.cmd_ready, 0);
        checkOutput({tag, "_rsp_valid"},   bus_a.rsp_valid, 0);
        checkOutput({tag, "_rsp_rdata"},   bus_a.rsp_rdata, 0);
        checkOutput({tag, "_rsp_err"},     bus_a.rsp_err, 0);
        checkOutput({tag, "_rsp_timeout"}, bus_a.rsp_timeout, 0);
        checkOutput({tag, "_paddr"},       bus_a.paddr, 0);
        checkOutput({tag, "_psel"},        bus_a.psel, 0);
        checkOutput({tag, "_penable"},     bus_a.penable, 0);
        checkOutput({tag, "_pwrite"},      bus_a.pwrite, 0);
        checkOutput({tag, "_pwdata"},      bus_a.pwdata, 0);
        checkOutput({tag, "_pstrb"},       bus_a.pstrb, 0);
        checkOutput({tag, "_pprot"},       bus_a.pprot, 0);
    endtask

    // One complete transfer on bus_a with the bench acting as APB slave.
    // Model: ACCESS lasts waits+1 cycles unless waits >= TMO, in which case
    // it lasts TMO cycles and ends in a timeout; the response appears at
    // cycle 2+ACCESS after accept and stays until rsp_ready (hold cycles late).
    task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input logic [2:0] prot, input int waits,
                                 input logic slvErr, input logic [31:0] rdata,
                                 input logic [NS-1:0] noise, input int hold);
        int            idx;
        int            acc;
        int            last;
        logic          expTmo;
        logic          expErr;
        logic [31:0]   expRdata;
        logic [NS-1:0] sel;

        idx      = int'(addr[13:12]);
        sel      = NS'(1) << idx;
        expTmo   = (waits >= TMO);
        acc      = expTmo ? TMO : waits + 1;
        expErr   = expTmo || slvErr;
        expRdata = (write || expErr) ? 32'h0 : rdata;
        last     = 2 + acc + hold;

        for (int k = 0; k < 8 && bus_a.cmd_ready !== 1'b1; k++) @(negedge pclk);
        checkOutput("cmd_ready_before_accept", bus_a.cmd_ready, 1);

        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_write = write;
        bus_a.cmd_addr  = addr;
        bus_a.cmd_wdata = wdata;
        bus_a.cmd_strb  = strb;
        bus_a.cmd_prot  = prot;
        bus_a.rsp_ready = 1'b0;
        for (int s = 0; s < NS; s++) bus_a.prdata[s*32 +: 32] = (s == idx) ? rdata : $urandom;
        @(negedge pclk);
        bus_a.cmd_valid = 1'b0;
        bus_a.cmd_addr  = $urandom;
        bus_a.cmd_wdata = $urandom;

        for (int c = 1; c <= last; c++) begin
            if (c <= 1 + acc) begin
                checkOutput("psel",          bus_a.psel, sel);
                checkOutput("penable",       bus_a.penable, (c >= 2) ? 1 : 0);
                checkOutput("paddr",         bus_a.paddr, addr);
                checkOutput("pwrite",        bus_a.pwrite, write);
                checkOutput("pwdata",        bus_a.pwdata, wdata);
                checkOutput("pstrb",         bus_a.pstrb, write ? strb : 4'h0);
                checkOutput("pprot",         bus_a.pprot, prot);
                checkOutput("rsp_valid_low", bus_a.rsp_valid, 0);
                checkOutput("cmd_ready_busy", bus_a.cmd_ready, 0);
            end else begin
                checkOutput("psel_resp",     bus_a.psel, 0);
                checkOutput("penable_resp",  bus_a.penable, 0);
                checkOutput("rsp_valid",     bus_a.rsp_valid, 1);
                checkOutput("rsp_err",       bus_a.rsp_err, expErr);
                checkOutput("rsp_timeout",   bus_a.rsp_timeout, expTmo);
                checkOutput("rsp_rdata",     bus_a.rsp_rdata, expRdata);
                checkOutput("cmd_ready_resp", bus_a.cmd_ready, 0);
            end
            bus_a.pready  = noise & ~sel;
            bus_a.pslverr = (NS'($urandom) & ~sel) | (slvErr ? sel : '0);
            if (c == 2 + waits && c <= 1 + acc) bus_a.pready |= sel;
            if (expTmo && c == 2 + acc) bus_a.pready |= sel;
            bus_a.rsp_ready = (c >= 2 + acc + hold);
            @(negedge pclk);
        end

        bus_a.pready    = '0;
        bus_a.pslverr   = '0;
        bus_a.rsp_ready = 1'b0;
        checkOutput("rsp_valid_after", bus_a.rsp_valid, 0);
        checkOutput("cmd_ready_after", bus_a.cmd_ready, 1);
        checkOutput("psel_after",      bus_a.psel, 0);
    endtask

    initial begin
        logic [31:0]   r;
        logic [1:0]    slv;
        int            w;

        preset          = 1'b1;
        bus_a.cmd_valid = 1'b0;
        bus_a.cmd_write = 1'b0;
        bus_a.cmd_addr  = '0;
        bus_a.cmd_wdata = '0;
        bus_a.cmd_strb  = '0;
        bus_a.cmd_prot  = '0;
        bus_a.rsp_ready = 1'b0;
        bus_a.pready    = '0;
        bus_a.prdata    = '0;
        bus_a.pslverr   = '0;
        bus_b.cmd_valid = 1'b0;
        bus_b.cmd_write = 1'b0;
        bus_b.cmd_addr  = '0;
        bus_b.cmd_wdata = '0;
        bus_b.cmd_strb  = '0;
        bus_b.cmd_prot  = '0;
        bus_b.rsp_ready = 1'b1;
        bus_b.pready    = '0;
        bus_b.prdata    = '0;
        bus_b.pslverr   = '0;

        $display("[TB] reset");
        repeat (3) @(negedge pclk);
        checkResetOutputs("reset");
        preset = 1'b0;
        checkOutput("cmd_ready_pre_rise", bus_a.cmd_ready, 0);
        @(negedge pclk);
        checkOutput("cmd_ready_rise", bus_a.cmd_ready, 1);

        $display("[TB] directed transfers");
        applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010, 0,   1'b0, 32'h0,         4'b0000, 0);
        applyStimulus(1'b0, 32'h0000_2004, 32'h0000_0000, 4'hF, 3'b000, 3,   1'b0, 32'h1234_5678, 4'b0000, 0);
        applyStimulus(1'b0, 32'h0000_1040, 32'h0000_0000, 4'h0, 3'b001, 0,   1'b1, 32'hAAAA_5555, 4'b1000, 0);
        applyStimulus(1'b1, 32'h0000_3FFC, 32'h0F0F_1234, 4'h5, 3'b111, 15,  1'b0, 32'h0,         4'b0001, 0);
        applyStimulus(1'b0, 32'h0000_3000, 32'h0000_0000, 4'h0, 3'b100, 100, 1'b0, 32'h7777_7777, 4'b0110, 0);
        applyStimulus(1'b0, 32'h0000_1008, 32'h0000_0000, 4'hF, 3'b000, 0,   1'b0, 32'hCAFE_0001, 4'b0000, 5);

        $display("[TB] reset during ACCESS");
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_write = 1'b0;
        bus_a.cmd_addr  = 32'h0000_3010;
        bus_a.rsp_ready = 1'b1;
        @(negedge pclk);
        bus_a.cmd_valid = 1'b0;
        checkOutput("rst_setup_psel", bus_a.psel, 4'b1000);
        repeat (2) @(negedge pclk);
        checkOutput("rst_access_penable", bus_a.penable, 1);
        preset = 1'b1;
        @(negedge pclk);
        checkResetOutputs("rst_mid");
        @(negedge pclk);
        preset = 1'b0;
        checkResetOutputs("rst_release");
        @(negedge pclk);
        checkOutput("rst_cmd_ready_rise", bus_a.cmd_ready, 1);
        checkOutput("rst_no_rsp",         bus_a.rsp_valid, 0);
        checkOutput("rst_no_psel",        bus_a.psel, 0);
        bus_a.rsp_ready = 1'b0;

        $display("[TB] random transfers");
        for (int n = 0; n < 40; n++) begin
            r   = $urandom;
            slv = 2'($urandom_range(0, 3));
            w   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 20)) : int'($urandom_range(0, 4));
            applyStimulus(1'($urandom), {r[31:14], slv, r[11:0]}, $urandom, 4'($urandom), 3'($urandom),
                          w, ($urandom_range(0, 3) == 0), $urandom, 4'($urandom), int'($urandom_range(0, 2)));
        end

        $display("[TB] decode error and unbounded wait");
        checkOutput("dec_cmd_ready", bus_b.cmd_ready, 1);
        bus_b.cmd_valid = 1'b1;
        bus_b.cmd_addr  = 32'h0000_3000;
        bus_b.pready    = 3'b111;
        @(negedge pclk);
        bus_b.cmd_valid = 1'b0;
        checkOutput("dec_rsp_valid",   bus_b.rsp_valid, 1);
        checkOutput("dec_rsp_err",     bus_b.rsp_err, 1);
        checkOutput("dec_rsp_timeout", bus_b.rsp_timeout, 0);
        checkOutput("dec_rsp_rdata",   bus_b.rsp_rdata, 0);
        checkOutput("dec_psel",        bus_b.psel, 0);
        checkOutput("dec_cmd_ready_busy", bus_b.cmd_ready, 0);
        @(negedge pclk);
        bus_b.pready = '0;
        checkOutput("dec_rsp_done",    bus_b.rsp_valid, 0);
        checkOutput("dec_psel_after",  bus_b.psel, 0);
        checkOutput("dec_cmd_ready_back", bus_b.cmd_ready, 1);

        bus_b.cmd_valid = 1'b1;
        bus_b.cmd_addr  = 32'h0000_2008;
        bus_b.prdata    = {32'h5A5A_0002, 32'h1111_1111, 32'h2222_2222};
        @(negedge pclk);
        bus_b.cmd_valid = 1'b0;
        checkOutput("nto_psel", bus_b.psel, 3'b100);
        repeat (30) begin
            checkOutput("nto_no_rsp", bus_b.rsp_valid, 0);
            @(negedge pclk);
        end
        checkOutput("nto_still_access", bus_b.penable, 1);
        bus_b.pready = 3'b100;
        @(negedge pclk);
        bus_b.pready = '0;
        checkOutput("nto_rsp_valid",   bus_b.rsp_valid, 1);
        checkOutput("nto_rsp_err",     bus_b.rsp_err, 0);
        checkOutput("nto_rsp_timeout", bus_b.rsp_timeout, 0);
        checkOutput("nto_rsp_rdata",   bus_b.rsp_rdata, 32'h5A5A_0002);
        @(negedge pclk);
        checkOutput("nto_rsp_done",    bus_b.rsp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
